sha256_digest_unloader: RTL and testbench
=========================================

Name: sha256_digest_unloader

Overview:
Read-out side of the hash result registers. It captures the 256-bit digest (H0..H7) in one cycle when `load` is asserted. It then streams the digest as 64-bit words over a valid/ready interface to the host/output bus, most significant word first. It sits between the SHA-256 core's final-state registers and the external read interface, and frees the core to start the next message as soon as capture completes.

Parameters:
DATA_W, 64, width of each output word in bits
WORDS, 4, number of output words per digest; DIGEST_W = DATA_W*WORDS (256)

Ports:
CLK  input  1  clock, all state updates on rising edge
RST  input  1  reset, asynchronous, active-high
load  input  1  single-cycle capture strobe from the core
digest_i  input  DIGEST_W  digest, H0 at [255:224] down to H7 at [31:0]
ready_i  input  1  downstream accepts data_o this cycle
data_o  output  DATA_W  current output word, registered
valid_o  output  1  data_o is valid, registered
last_o  output  1  data_o is the final word of the digest, registered
busy_o  output  1  unloader is holding an unsent digest
done_o  output  1  one-cycle pulse after the final word transfers
ovf_o  output  1  sticky: a load arrived while busy and was dropped

Behaviour:
- Reset: RST=1 asynchronously clears everything. data_o=0, valid_o=0, last_o=0, busy_o=0, done_o=0, ovf_o=0. The state returns to IDLE, the word index goes to 0, and the capture buffer goes to 0. Reset mid-stream abandons the digest; no further words are emitted.
- States:
  - IDLE: valid_o=0, busy_o=0.
  - SEND: valid_o=1, busy_o=1.
- IDLE -> SEND on load=1:
  - The buffer captures digest_i on that edge.
  - On the next cycle, valid_o=1 and data_o=digest_i[255:192] (H0||H1), with index=0.
  - Latency from load to first valid is 1 cycle.
- Transfer: occurs on a rising edge where valid_o=1 and ready_i=1.
  - data_o advances to the next lower 64-bit slice; index increments by 1.
- Stall: while valid_o=1 and ready_i=0, data_o, last_o and index hold stable. valid_o never drops without a transfer.
- Word order: index k emits buffer[DIGEST_W-1-k*DATA_W -: DATA_W].
- last_o=1 exactly when valid_o=1 and index==WORDS-1.
- Final transfer (index==WORDS-1 and ready_i=1):
  - Next cycle: done_o=1 for one cycle.
  - If load is not asserted in the final-transfer cycle: state -> IDLE, and valid_o, last_o and data_o go to 0.
  - If load=1 in the same cycle as the final transfer: the new digest is accepted with no bubble. The next cycle shows valid_o=1 with the new word 0, and done_o=1 still pulses.
- load while busy_o=1 (other than in the final-transfer cycle): ignored, and ovf_o sets to 1. ovf_o stays set until RST.
- ready_i while valid_o=0: no effect.
- data_o is 0 whenever valid_o=0.
- Index width is clog2(WORDS). WORDS>=2 is required. The index never wraps past WORDS-1.
- Throughput: one word per cycle with ready_i held high, so a full digest streams in WORDS cycles after first valid.

Test Plan:
- Basic unload:
  - Stimulus: digest_i = "abc" digest ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad, load=1 for 1 cycle, ready_i=1.
  - Required: words 0xba7816bf8f01cfea, 0x414140de5dae2223, 0xb00361a396177a9c, 0xb410ff61f20015ad on 4 consecutive cycles. last_o=1 only on the 4th word. done_o pulses the cycle after; valid_o=0 and busy_o=0 afterwards.
- Backpressure:
  - Stimulus: same digest, with ready_i low for 3 cycles on word 1.
  - Required: data_o holds 0x414140de5dae2223 with valid_o=1 throughout the stall. The sequence and count are unchanged: exactly 4 transfers.
- Overflow:
  - Stimulus: load a second digest while index=1.
  - Required: ovf_o=1 and stays high. The first digest completes intact; no words from the second digest appear.
- Back-to-back:
  - Stimulus: load new digest 0x00..01 (256-bit) in the same cycle as the final transfer.
  - Required: done_o=1 and valid_o=1 with data_o=0 on the next cycle. last_o then asserts on word 3 = 0x0000000000000001. ovf_o stays 0.
- Reset mid-stream:
  - Stimulus: assert RST asynchronously (between clock edges) while index=2.
  - Required: all outputs go to 0 immediately. After release, no words are emitted until the next load.
- Idle noise:
  - Stimulus: toggle ready_i and digest_i with load=0 for 10 cycles.
  - Required: valid_o=0, data_o=0, done_o=0 throughout.

Source files
------------

// File: rtl/sha256_digest_unloader.sv
// Captures a SHA-256 digest in one cycle and streams it out as DATA_W-bit words,
// most significant word first, over a valid/ready handshake.
module sha256_digest_unloader #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned WORDS  = 4
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     load,
  input  logic [DATA_W*WORDS-1:0]  digest_i,
  input  logic                     ready_i,
  output logic [DATA_W-1:0]        data_o,
  output logic                     valid_o,
  output logic                     last_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     ovf_o
);

  localparam int unsigned DIGEST_W = DATA_W * WORDS;
  localparam int unsigned IDX_W    = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t              state, state_n;
  logic [IDX_W-1:0]    idx, idx_n;
  logic [DIGEST_W-1:0] digest_q, digest_n;
  logic [DATA_W-1:0]   data_n;
  logic                valid_n, last_n, busy_n, done_n, ovf_n;
  logic                xfer_c, final_xfer_c;

  // Word k of a digest, counted from the most significant end.
  function automatic logic [DATA_W-1:0] word_at(input logic [DIGEST_W-1:0] d,
                                                input logic [IDX_W-1:0]    k);
    logic [DIGEST_W-1:0] shifted;
    shifted = d << (DATA_W * k);
    return shifted[DIGEST_W-1 -: DATA_W];
  endfunction

  assign xfer_c       = valid_o & ready_i;
  assign final_xfer_c = xfer_c & last_o;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      idx      <= '0;
      digest_q <= '0;
      data_o   <= '0;
      valid_o  <= 1'b0;
      last_o   <= 1'b0;
      busy_o   <= 1'b0;
      done_o   <= 1'b0;
      ovf_o    <= 1'b0;
    end else begin
      state    <= state_n;
      idx      <= idx_n;
      digest_q <= digest_n;
      data_o   <= data_n;
      valid_o  <= valid_n;
      last_o   <= last_n;
      busy_o   <= busy_n;
      done_o   <= done_n;
      ovf_o    <= ovf_n;
    end
  end

  always_comb begin
    state_n  = state;
    idx_n    = idx;
    digest_n = digest_q;
    data_n   = data_o;
    valid_n  = valid_o;
    last_n   = last_o;
    done_n   = 1'b0;
    ovf_n    = ovf_o;

    unique case (state)
      IDLE: begin
        if (load) begin
          state_n  = SEND;
          digest_n = digest_i;
          idx_n    = '0;
          data_n   = digest_i[DIGEST_W-1 -: DATA_W];
          valid_n  = 1'b1;
          last_n   = 1'b0;
        end
      end
      SEND: begin
        if (final_xfer_c) begin
          done_n = 1'b1;
          // A load coinciding with the final transfer starts the next digest without a bubble.
          if (load) begin
            digest_n = digest_i;
            idx_n    = '0;
            data_n   = digest_i[DIGEST_W-1 -: DATA_W];
            valid_n  = 1'b1;
            last_n   = 1'b0;
          end else begin
            state_n = IDLE;
            idx_n   = '0;
            data_n  = '0;
            valid_n = 1'b0;
            last_n  = 1'b0;
          end
        end else begin
          if (xfer_c) begin
            idx_n  = idx + IDX_W'(1);
            data_n = word_at(digest_q, idx + IDX_W'(1));
            last_n = ((idx + IDX_W'(1)) == LAST_IDX);
          end
          if (load) ovf_n = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase

    busy_n = (state_n == SEND);
  end

endmodule

// File: tb/tb_sha256_digest_unloader.sv
// Randomized bench for sha256_digest_unloader checked against a queue-based
// model of the words still owed to the host.
module tb_sha256_digest_unloader;

  localparam logic [255:0] ABC = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] ONE = 256'h1;

  logic         CLK = 1'b0;
  logic         RST;
  logic         load;
  logic [255:0] digest_i;
  logic         ready_i;
  logic [63:0]  data_o;
  logic         valid_o, last_o, busy_o, done_o, ovf_o;

  int unsigned errors = 0;
  int unsigned checks = 0;

  logic [63:0] mq[$];
  bit          m_done;
  bit          m_ovf;

  sha256_digest_unloader #(.DATA_W(64), .WORDS(4)) dut (
    .CLK(CLK), .RST(RST), .load(load), .digest_i(digest_i), .ready_i(ready_i),
    .data_o(data_o), .valid_o(valid_o), .last_o(last_o), .busy_o(busy_o),
    .done_o(done_o), .ovf_o(ovf_o)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    bit v;
    v = (mq.size() != 0);
    check({tag, ".valid"}, 64'(valid_o), 64'(v));
    check({tag, ".data"},  data_o, v ? mq[0] : 64'h0);
    check({tag, ".last"},  64'(last_o), 64'(mq.size() == 1));
    check({tag, ".busy"},  64'(busy_o), 64'(v));
    check({tag, ".done"},  64'(done_o), 64'(m_done));
    check({tag, ".ovf"},   64'(ovf_o),  64'(m_ovf));
  endtask

  function automatic logic [255:0] rand_digest();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  // Drive one cycle, advance the model at the edge, then compare just after it.
  task automatic step(input string tag, input bit l, input bit r, input logic [255:0] d);
    load = l; ready_i = r; digest_i = d;
    @(posedge CLK);
    if (mq.size() != 0 && r) begin
      void'(mq.pop_front());
      m_done = (mq.size() == 0);
    end else begin
      m_done = 1'b0;
    end
    if (l) begin
      if (mq.size() == 0) begin
        for (int k = 0; k < 4; k++) mq.push_back(d[255 - 64*k -: 64]);
      end else begin
        m_ovf = 1'b1;
      end
    end
    #1 check_all(tag);
  endtask

  task automatic model_reset();
    mq.delete();
    m_done = 1'b0;
    m_ovf  = 1'b0;
  endtask

  task automatic pulse_reset(input string tag);
    #2 RST = 1'b1;
    model_reset();
    #1 check_all(tag);
    @(posedge CLK);
    #3 RST = 1'b0;
    #1 check_all({tag, ".post"});
  endtask

  initial begin
    RST = 1'b1; load = 1'b0; ready_i = 1'b0; digest_i = '0;
    model_reset();
    #12 check_all("reset");
    RST = 1'b0;

    // Basic unload of the "abc" digest
    step("basic.load", 1'b1, 1'b1, ABC);
    check("basic.w0", data_o, 64'hba7816bf8f01cfea);
    for (int i = 0; i < 5; i++) step("basic", 1'b0, 1'b1, '0);
    check("basic.idle_after", 64'(busy_o), 64'h0);

    // Backpressure on word 1
    step("bp.load", 1'b1, 1'b0, ABC);
    step("bp.w0", 1'b0, 1'b1, '0);
    for (int i = 0; i < 3; i++) begin
      step("bp.stall", 1'b0, 1'b0, '0);
      check("bp.hold", data_o, 64'h414140de5dae2223);
    end
    for (int i = 0; i < 4; i++) step("bp.drain", 1'b0, 1'b1, '0);

    // Back-to-back load on the final transfer
    step("b2b.load", 1'b1, 1'b1, ABC);
    for (int i = 0; i < 3; i++) step("b2b", 1'b0, 1'b1, '0);
    step("b2b.reload", 1'b1, 1'b1, ONE);
    check("b2b.done", 64'(done_o), 64'h1);
    check("b2b.w0", data_o, 64'h0);
    for (int i = 0; i < 3; i++) step("b2b.second", 1'b0, 1'b1, '0);
    check("b2b.w3", data_o, 64'h1);
    check("b2b.last", 64'(last_o), 64'h1);
    for (int i = 0; i < 2; i++) step("b2b.tail", 1'b0, 1'b1, '0);

    // Overflow: second load while index is 1
    step("ovf.load", 1'b1, 1'b1, ABC);
    step("ovf.w0", 1'b0, 1'b1, '0);
    step("ovf.drop", 1'b1, 1'b0, rand_digest());
    check("ovf.set", 64'(ovf_o), 64'h1);
    for (int i = 0; i < 5; i++) step("ovf.drain", 1'b0, 1'b1, '0);

    // Reset mid-stream at index 2
    step("rst.load", 1'b1, 1'b1, rand_digest());
    step("rst.w0", 1'b0, 1'b1, '0);
    step("rst.w1", 1'b0, 1'b1, '0);
    pulse_reset("rst.mid");
    for (int i = 0; i < 3; i++) step("rst.quiet", 1'b0, 1'b1, '0);

    // Idle noise
    for (int i = 0; i < 10; i++) step("idle", 1'b0, 1'($urandom_range(0, 1)), rand_digest());

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step("rand", ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) != 0), rand_digest());
      if (i == 200) pulse_reset("rand.rst");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
